// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the round-robin counter scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sched_state_t FSM encoding, SCHED_NREQ / SCHED_N default sizes.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int SCHED_NREQ = 4;
  localparam int SCHED_N    = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority pick: the first requester at or after ptr+1 (mod NREQ).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when to act on valid/idx.
// Ports: req (request vector), ptr (last served index) -> valid (any request), idx (winner).
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  // Scan from the farthest offset down to ptr+1 so that the nearest
  // requester after ptr is the last assignment and therefore wins.
  // Offset NREQ wraps back onto ptr itself, giving it lowest priority.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler sharing one loadable up/down counter among NREQ requesters.
// Latency: request seen in IDLE at t, LOAD t+1, RUN from t+2, done at t+3+k (k steps to terminal).
// Backpressure: requesters hold req until done; dropping req[own] aborts; others wait until IDLE.
// Ports: clk/clr (async, active-high); req, req_val (slice i = [i*N +: N]), req_up in;
//        gnt (one-hot owner in LOAD/RUN), done (one-cycle pulse), busy, count, rco out.
module cnt_rr_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = SCHED_NREQ,
  parameter int N    = SCHED_N
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*N-1:0] req_val,
  input  logic [NREQ-1:0] req_up,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [N-1:0]    count,
  output logic            rco
);

  localparam int          OW  = $clog2(NREQ);
  localparam logic [N-1:0] ONE = N'(1);

  sched_state_t      state_q, state_d;
  logic [OW-1:0]     own_q, own_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [N-1:0]      count_q, count_d;
  logic              dir_q, dir_d;

  logic              arb_vld;
  logic [OW-1:0]     arb_idx;
  logic [NREQ-1:0][N-1:0] val_arr;

  assign val_arr = req_val;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .valid (arb_vld),
    .idx   (arb_idx)
  );

  // Terminal flag: all-ones going up, zero going down.
  assign rco = dir_q ? (&count_q) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          own_d   = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!req[own_q]) begin
          // Abort: owner gave up before the run started; count untouched.
          ptr_d   = own_q;
          state_d = IDLE;
        end else begin
          count_d = val_arr[own_q];
          dir_d   = req_up[own_q];
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[own_q]) begin
          // Abort wins over terminal: no done, count holds where it stopped.
          ptr_d   = own_q;
          state_d = IDLE;
        end else if (rco) begin
          state_d = DONE;
        end else begin
          count_d = dir_q ? (count_q + ONE) : (count_q - ONE);
        end
      end
      DONE: begin
        ptr_d   = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      own_q   <= '0;
      // Start just behind requester 0 so it is first in line after reset.
      ptr_q   <= OW'(NREQ - 1);
      count_q <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // Moore outputs decoded from registered state and owner.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q == LOAD || state_q == RUN) gnt[own_q] = 1'b1;
    if (state_q == DONE)                   done[own_q] = 1'b1;
  end

  assign busy  = (state_q != IDLE);
  assign count = count_q;

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Directed bench for cnt_rr_sched (NREQ=4, N=8) with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Ends with a single summary line.
module tb_cnt_rr_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] req_val;
  logic [3:0]  req_up;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  count;
  logic        rco;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnt_rr_sched #(.NREQ(4), .N(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .req_val (req_val),
    .req_up  (req_up),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .count   (count),
    .rco     (rco)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse;
    req = '0;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  // Called in the IDLE cycle where the grant decision is made; returns in the
  // IDLE cycle following DONE.
  task automatic run_one(input int own, input logic [7:0] d, input logic up, input bit drop);
    int k;
    k = up ? (255 - int'(d)) : int'(d);
    tick();
    chk("load_gnt", gnt, 32'(1 << own));
    chk("load_1hot", 32'($onehot0(gnt)), 32'd1);
    tick();
    chk("run_first", count, d);
    chk("run_gnt", gnt, 32'(1 << own));
    repeat (k) tick();
    chk("run_term", count, up ? 32'hFF : 32'h00);
    chk("run_rco", rco, 1);
    tick();
    chk("done_pulse", done, 32'(1 << own));
    chk("done_gnt", gnt, 0);
    if (drop) req = '0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    req     = '0;
    req_val = '0;
    req_up  = '0;
    clr     = 1'b1;
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_rco", rco, 0);
    clr = 1'b0;

    // Requester 0, FC up: cycle 0 IDLE decision.
    req = 4'b0001; req_val[7:0] = 8'hFC; req_up = 4'b0001;
    chk("t1_c0_busy", busy, 0);
    tick();
    chk("t1_c1_gnt", gnt, 4'b0001);
    chk("t1_c1_busy", busy, 1);
    tick(); chk("t1_c2_cnt", count, 8'hFC);
    tick(); chk("t1_c3_cnt", count, 8'hFD);
    tick(); chk("t1_c4_cnt", count, 8'hFE); chk("t1_c4_done", done, 0);
    tick(); chk("t1_c5_cnt", count, 8'hFF); chk("t1_c5_rco", rco, 1);
    tick(); chk("t1_c6_done", done, 4'b0001); chk("t1_c6_busy", busy, 1);
    req = '0;
    tick(); chk("t1_c7_busy", busy, 0); chk("t1_c7_done", done, 0);

    // Requester 1, 03 down; count remains 0 in IDLE afterwards.
    req = 4'b0010; req_val[15:8] = 8'h03; req_up = 4'b0000;
    run_one(1, 8'h03, 1'b0, 1'b1);
    chk("t2_idle_cnt", count, 0);
    tick();
    chk("t2_idle_cnt2", count, 0);
    chk("t2_idle_busy", busy, 0);

    // Requesters 0 and 2 alternate, terminal values, from fresh priority.
    clr_pulse();
    req_val[7:0] = 8'hFF; req_val[23:16] = 8'hFF; req_up = 4'b0101;
    req = 4'b0101;
    run_one(0, 8'hFF, 1'b1, 1'b0);
    run_one(2, 8'hFF, 1'b1, 1'b0);
    run_one(0, 8'hFF, 1'b1, 1'b0);
    run_one(2, 8'hFF, 1'b1, 1'b1);

    // Requester 3, 10 down, aborted in its third RUN cycle.
    req = 4'b1000; req_val[31:24] = 8'h10; req_up = 4'b0000;
    tick(); chk("t4_load_gnt", gnt, 4'b1000);
    tick(); chk("t4_r1_cnt", count, 8'h10);
    tick(); chk("t4_r2_cnt", count, 8'h0F);
    tick(); chk("t4_r3_cnt", count, 8'h0E); chk("t4_r3_done", done, 0);
    req = '0;
    tick();
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_gnt", gnt, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_cnt", count, 8'h0E);
    tick();
    chk("t4_hold_cnt", count, 8'h0E);
    chk("t4_hold_done", done, 0);

    // Async clear mid-run at count 40.
    req = 4'b0010; req_val[15:8] = 8'h42; req_up = 4'b0000;
    tick(); chk("t5_load_gnt", gnt, 4'b0010);
    tick(); chk("t5_r1_cnt", count, 8'h42);
    tick(); chk("t5_r2_cnt", count, 8'h41);
    tick(); chk("t5_r3_cnt", count, 8'h40);
    clr = 1'b1;
    #1;
    chk("t5_clr_gnt", gnt, 0);
    chk("t5_clr_done", done, 0);
    chk("t5_clr_busy", busy, 0);
    chk("t5_clr_cnt", count, 0);
    chk("t5_clr_rco", rco, 0);
    clr = 1'b0;
    req = 4'b0011; req_val[7:0] = 8'hFF; req_val[15:8] = 8'hFF; req_up = 4'b0011;
    run_one(0, 8'hFF, 1'b1, 1'b0);
    run_one(1, 8'hFF, 1'b1, 1'b1);

    // All four held with distinct starts: rotation 0,1,2,3,0.
    clr_pulse();
    req_val = {8'hFB, 8'hFC, 8'hFD, 8'hFE};
    req_up  = 4'b1111;
    req     = 4'b1111;
    run_one(0, 8'hFE, 1'b1, 1'b0);
    run_one(1, 8'hFD, 1'b1, 1'b0);
    run_one(2, 8'hFC, 1'b1, 1'b0);
    run_one(3, 8'hFB, 1'b1, 1'b0);
    run_one(0, 8'hFE, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_rr_sched.md
# cnt_rr_sched

Round-robin scheduler that shares one internal up/down loadable counter among `NREQ` requesters. Each requester asks for a timed count run with a start value and a direction. The block grants one requester at a time, loads its value, and counts to the terminal value (all-ones when counting up, zero when counting down). It then pulses that requester's `done`. It sits between the MCU-side timing/delay clients and the shared count resource.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `N`, 8, counter width in bits
- `clk`  in  1  clock, rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  request per requester; held high until its `done`, dropping it aborts
- `req_val`  in  NREQ*N  start value; slice i is `[i*N +: N]`
- `req_up`  in  NREQ  direction per requester (1 = up, 0 = down)
- `gnt`  out  NREQ  one-hot grant, high in LOAD and RUN for the owner
- `done`  out  NREQ  one-cycle completion pulse to the owner
- `busy`  out  1  high whenever state is not IDLE
- `count`  out  N  current counter value
- `rco`  out  1  combinational terminal flag: (dir=1 and count all-ones) or (dir=0 and count==0)

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any `req` bit is high, the arbiter picks the first requester at or after `ptr+1` (mod NREQ).
  - Latch its index into `own` and go to LOAD.
  - Otherwise stay in IDLE; `count` holds its value.
- LOAD:
  - `count <= req_val[own]` and `dir <= req_up[own]`.
  - Go to RUN.
- RUN:
  - If `rco` is high, go to DONE and do not step `count`.
  - Otherwise `count <= count ± 1` according to `dir`.
- DONE:
  - `done[own]` is high for this single cycle.
  - `ptr <= own`.
  - Go to IDLE.
- Abort: if `req[own]` is low in LOAD or RUN, go to IDLE next cycle. No `done` is issued, `ptr <= own`, and `count` holds.
- Arithmetic is modulo 2^N, but the terminal check always stops the run before any wrap.
- `req_val` and `req_up` are sampled only in LOAD; later changes during RUN are ignored.
- New requests that arrive during LOAD/RUN/DONE wait until IDLE. Requests never preempt a run.
- Fairness: with all `req` bits held, grants rotate 0,1,…,NREQ-1.

## Timing
- Reset values: state IDLE, `gnt`=0, `done`=0, `busy`=0, `count`=0, `dir`=1, `ptr`=NREQ-1 (so requester 0 has top priority first).
- `clr` takes effect immediately (asynchronous), including mid-run. There is no `done` for the interrupted run.
- Cycle numbering: request seen in IDLE at cycle t. LOAD is cycle t+1. First RUN cycle is t+2 with `count`=D.
- Number of steps k: up run k = 2^N−1−D; down run k = D.
- `done` pulse occurs at cycle t+3+k.
- Minimum turnaround is 4 cycles (k=0). The next grant decision is made in the IDLE cycle that follows DONE.
- `gnt`, `done` and `busy` are Moore outputs decoded from registered state/`own`. `rco` is combinational from `count`/`dir`.

## Structure
- Package `cnt_sched_pkg` contains:
  - state enum typedef `sched_state_t` (IDLE, LOAD, RUN, DONE);
  - default constants `SCHED_NREQ`=4 and `SCHED_N`=8.
- Sub-module `rr_arbiter` (parameter `NREQ`; inputs `req` and `ptr`; outputs `valid` and `idx`).
  - Purely combinational rotate-priority pick.
  - `ptr` register and FSM live in the top.
- The counter register and its step/terminal logic are inline in the top.

## Test plan
- Reset, then `req[0]`=1, `req_val`=8'hFC, up: `gnt[0]` high from cycle 1; `count` FC,FD,FE,FF; `done[0]` pulses at cycle 6; `busy` drops at cycle 7.
- `req[1]`=1, `req_val`=8'h03, down: `count` 3,2,1,0; `done[1]` pulses at cycle 6; `count` stays 0 in IDLE.
- `req[0]` and `req[2]` both held, each `req_val` at terminal (FF up): grant order 0,2,0,2; each `done` 4 cycles apart; never two `gnt` bits high.
- `req[3]`, `req_val`=8'h10, down; drop `req[3]` in the 3rd RUN cycle: state returns to IDLE next cycle; `done` never asserts; `count` holds 8'h0E.
- Assert `clr` during a run with `count`=8'h40: all outputs zero in the same cycle. After release, `req[1]` and `req[0]` together: `req[0]` is granted first.
- All four held, each with distinct `req_val` (FE up): grants 0,1,2,3,0; each `done` matches the owner's index.
